lcd_cmd_sequencer: RTL
======================

LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

Interface
REQ-001 Parameter RST_LOW_CYCLES, default 1024, cycles lcd_rst_n is held low in the power-on/hardware reset sequence (minimum 1).
REQ-002 Parameter RST_WAIT_CYCLES, default 65535, cycles waited after lcd_rst_n rises before the block accepts commands (minimum 1).
REQ-003 clk  in  1  sole clock; all logic on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 sync_reset  in  1  synchronous abort to S_IDLE; no hardware reset pulse.
REQ-006 hw_reset_req  in  1  single-cycle request to rerun the hardware reset sequence; honoured only in S_IDLE.
REQ-007 cmd_valid  in  1  command descriptor valid.
REQ-008 cmd_ready  out  1  descriptor accepted when cmd_valid and cmd_ready are both high.
REQ-009 cmd_code  in  8  command byte.
REQ-010 cmd_param_cnt  in  16  number of parameter/pixel bytes following the command (0..65535).
REQ-011 cmd_delay  in  16  idle cycles inserted after the last byte (0 = none).
REQ-012 par_valid  in  1  parameter byte valid.
REQ-013 par_ready  out  1  parameter byte accepted when par_valid and par_ready are both high.
REQ-014 par_data  in  8  parameter byte.
REQ-015 byte_load  out  1  single-cycle load strobe to the SPI byte serializer.
REQ-016 byte_data  out  8  byte presented to the serializer; valid while byte_load is high.
REQ-017 byte_done  in  1  single-cycle pulse from the serializer when a byte has been shifted out.
REQ-018 dcx  out  1  LCD data/command select: 0 = command, 1 = parameter.
REQ-019 lcd_rst_n  out  1  LCD hardware reset, active low.
REQ-020 busy  out  1  high in every state except S_IDLE.
REQ-021 cmd_done  out  1  single-cycle pulse when a command, including its delay, completes.

Function
REQ-022 The FSM SHALL be one-hot with states S_HW_RST_LOW, S_HW_RST_WAIT, S_IDLE, S_CMD_LOAD, S_CMD_WAIT, S_PAR_REQ, S_PAR_LOAD, S_PAR_WAIT, S_DELAY.
REQ-023 S_HW_RST_LOW: lcd_rst_n = 0 for RST_LOW_CYCLES cycles, then -> S_HW_RST_WAIT.
REQ-024 S_HW_RST_WAIT: lcd_rst_n = 1 for RST_WAIT_CYCLES cycles, then -> S_IDLE.
REQ-025 The cycle counters SHALL be wide enough for both parameters.
REQ-026 S_IDLE behaviour:
- cmd_ready = 1.
- Descriptor handshake: capture cmd_code, cmd_param_cnt and cmd_delay, then -> S_CMD_LOAD.
- hw_reset_req without a handshake -> S_HW_RST_LOW.
- Both in the same cycle: the command wins and hw_reset_req is dropped.
REQ-027 S_CMD_LOAD: byte_load = 1, byte_data = captured code, dcx = 0 (one cycle), then -> S_CMD_WAIT. This cycle is exactly one cycle after the handshake.
REQ-028 S_CMD_WAIT: hold dcx = 0 until byte_done, then -> S_PAR_REQ if the remaining count is nonzero, else -> S_DELAY.
REQ-029 S_PAR_REQ: par_ready = 1 and dcx = 1. On a handshake, register par_data and -> S_PAR_LOAD. Waiting for par_valid is unbounded.
REQ-030 S_PAR_LOAD: byte_load = 1, byte_data = registered byte, decrement the remaining count, then -> S_PAR_WAIT.
REQ-031 S_PAR_WAIT: on byte_done -> S_PAR_REQ if the remaining count is nonzero, else -> S_DELAY.
REQ-032 S_DELAY: count cmd_delay cycles, then pulse cmd_done and -> S_IDLE. With cmd_delay = 0, cmd_done pulses in the first S_DELAY cycle.
REQ-033 dcx SHALL change only in S_IDLE, S_CMD_LOAD or S_PAR_REQ, never while a byte is in flight.
REQ-034 byte_done received outside S_CMD_WAIT/S_PAR_WAIT SHALL be ignored.
REQ-035 cmd_ready and par_ready SHALL never be high in the same cycle.
REQ-036 The remaining-count register SHALL be 16 bits and SHALL NOT wrap below 0.
REQ-037 sync_reset SHALL force S_IDLE on the next edge from any state, with these outputs:
- byte_load = 0, dcx = 1, cmd_done = 0.
- lcd_rst_n = 1.
- Captured descriptor discarded.
REQ-038 sync_reset SHALL take priority over every other input.

Reset
REQ-039 While reset is high, outputs SHALL be: state S_HW_RST_LOW, lcd_rst_n = 0, byte_load = 0, byte_data = 0, dcx = 1, cmd_ready = 0, par_ready = 0, busy = 1, cmd_done = 0, all counters 0.
REQ-040 After reset is released, the hardware reset sequence SHALL run unconditionally.
REQ-041 Reset asserted mid-transfer SHALL abandon the transfer; no cmd_done is issued.

Verification
REQ-042 Power-up with RST_LOW_CYCLES = 4, RST_WAIT_CYCLES = 8 -> lcd_rst_n low 4 cycles, high 8 cycles, then cmd_ready = 1.
REQ-043 Command 0x11, cnt = 0, delay = 5 -> byte_load with 0x11 and dcx = 0 one cycle after the handshake; after byte_done, 5 idle cycles, then one cmd_done pulse.
REQ-044 Command 0x2A, cnt = 4, params 0x00 0x00 0x00 0x7F, par_valid stalled 3 cycles before the 3rd byte -> byte sequence 0x2A (dcx = 0) then four bytes (dcx = 1) in order; par_ready held through the stall.
REQ-045 sync_reset during the 2nd parameter of a cnt = 3 command -> S_IDLE next cycle, no cmd_done, no further byte_load, dcx = 1.
REQ-046 Spurious byte_done in S_IDLE and S_PAR_REQ -> no state change. Simultaneous cmd_valid and hw_reset_req in S_IDLE -> command executes and lcd_rst_n stays high.

Source files
------------

// File: rtl/lcd_cmd_sequencer.sv
// LCD command sequencer: runs the LCD hardware reset sequence, then issues
// command descriptors (command byte plus optional parameter bytes and a
// trailing delay) to an external SPI byte serializer one byte at a time.
module lcd_cmd_sequencer #(
    parameter int unsigned RST_LOW_CYCLES  = 1024,
    parameter int unsigned RST_WAIT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sync_reset,
    input  logic        hw_reset_req,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_code,
    input  logic [15:0] cmd_param_cnt,
    input  logic [15:0] cmd_delay,
    input  logic        par_valid,
    output logic        par_ready,
    input  logic [7:0]  par_data,
    output logic        byte_load,
    output logic [7:0]  byte_data,
    input  logic        byte_done,
    output logic        dcx,
    output logic        lcd_rst_n,
    output logic        busy,
    output logic        cmd_done
);

    // Counter must hold the larger reset parameter and any 16-bit delay.
    localparam int unsigned MAX_RST = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ?
                                      RST_LOW_CYCLES : RST_WAIT_CYCLES;
    localparam int unsigned RST_W   = $clog2(MAX_RST + 1);
    localparam int unsigned CNT_W   = (RST_W > 16) ? RST_W : 16;
    localparam int unsigned CODE_W  = 8;
    localparam int unsigned LEN_W   = 16;

    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RST_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYCLES - 1);

    typedef enum logic [8:0] {
        S_HW_RST_LOW  = 9'h001,
        S_HW_RST_WAIT = 9'h002,
        S_IDLE        = 9'h004,
        S_CMD_LOAD    = 9'h008,
        S_CMD_WAIT    = 9'h010,
        S_PAR_REQ     = 9'h020,
        S_PAR_LOAD    = 9'h040,
        S_PAR_WAIT    = 9'h080,
        S_DELAY       = 9'h100
    } state_t;

    // State and datapath registers
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    r_rem;
    logic [CODE_W-1:0]   r_code;
    logic [LEN_W-1:0]    r_delay;
    logic [CODE_W-1:0]   r_par;

    // Registered outputs
    logic                r_cmd_ready;
    logic                r_par_ready;
    logic                r_byte_load;
    logic [CODE_W-1:0]   r_byte_data;
    logic                r_dcx;
    logic                r_lcd_rst_n;
    logic                r_busy;
    logic                r_cmd_done;

    // Next-state values
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [LEN_W-1:0]    w_rem_nxt;
    logic [CODE_W-1:0]   w_code_nxt;
    logic [LEN_W-1:0]    w_delay_nxt;
    logic [CODE_W-1:0]   w_par_nxt;

    logic                w_cmd_ready_nxt;
    logic                w_par_ready_nxt;
    logic                w_byte_load_nxt;
    logic [CODE_W-1:0]   w_byte_data_nxt;
    logic                w_dcx_nxt;
    logic                w_lcd_rst_n_nxt;
    logic                w_busy_nxt;
    logic                w_cmd_done_nxt;

    logic                w_cmd_hs;
    logic                w_par_hs;

    assign w_cmd_hs = cmd_valid & r_cmd_ready;
    assign w_par_hs = par_valid & r_par_ready;

    // State register plus datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_HW_RST_LOW;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_code      <= '0;
            r_delay     <= '0;
            r_par       <= '0;
            r_cmd_ready <= 1'b0;
            r_par_ready <= 1'b0;
            r_byte_load <= 1'b0;
            r_byte_data <= '0;
            r_dcx       <= 1'b1;
            r_lcd_rst_n <= 1'b0;
            r_busy      <= 1'b1;
            r_cmd_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rem       <= w_rem_nxt;
            r_code      <= w_code_nxt;
            r_delay     <= w_delay_nxt;
            r_par       <= w_par_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_par_ready <= w_par_ready_nxt;
            r_byte_load <= w_byte_load_nxt;
            r_byte_data <= w_byte_data_nxt;
            r_dcx       <= w_dcx_nxt;
            r_lcd_rst_n <= w_lcd_rst_n_nxt;
            r_busy      <= w_busy_nxt;
            r_cmd_done  <= w_cmd_done_nxt;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they
    // line up with the state they describe once registered.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rem_nxt   = r_rem;
        w_code_nxt  = r_code;
        w_delay_nxt = r_delay;
        w_par_nxt   = r_par;

        if (sync_reset) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_rem_nxt   = '0;
            w_code_nxt  = '0;
            w_delay_nxt = '0;
        end else begin
            case (r_state)
                S_HW_RST_LOW: begin
                    if (r_cnt == LOW_LAST) begin
                        w_state_nxt = S_HW_RST_WAIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_HW_RST_WAIT: begin
                    if (r_cnt == WAIT_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    // A descriptor handshake outranks a same-cycle reset request.
                    if (w_cmd_hs) begin
                        w_code_nxt  = cmd_code;
                        w_rem_nxt   = cmd_param_cnt;
                        w_delay_nxt = cmd_delay;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_CMD_LOAD;
                    end else if (hw_reset_req) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_HW_RST_LOW;
                    end
                end
                S_CMD_LOAD: begin
                    w_state_nxt = S_CMD_WAIT;
                end
                S_CMD_WAIT: begin
                    if (byte_done) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_rem != '0) ? S_PAR_REQ : S_DELAY;
                    end
                end
                S_PAR_REQ: begin
                    if (w_par_hs) begin
                        w_par_nxt   = par_data;
                        w_state_nxt = S_PAR_LOAD;
                    end
                end
                S_PAR_LOAD: begin
                    // Saturating decrement: the count never wraps below zero.
                    if (r_rem != '0) begin
                        w_rem_nxt = r_rem - LEN_W'(1);
                    end
                    w_state_nxt = S_PAR_WAIT;
                end
                S_PAR_WAIT: begin
                    if (byte_done) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_rem != '0) ? S_PAR_REQ : S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (r_cnt == CNT_W'(r_delay)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HW_RST_LOW;
                end
            endcase
        end

        w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
        w_par_ready_nxt = (w_state_nxt == S_PAR_REQ);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_lcd_rst_n_nxt = (w_state_nxt != S_HW_RST_LOW);
        w_byte_load_nxt = (w_state_nxt == S_CMD_LOAD) || (w_state_nxt == S_PAR_LOAD);

        w_byte_data_nxt = '0;
        if (w_state_nxt == S_CMD_LOAD) begin
            w_byte_data_nxt = w_code_nxt;
        end else if (w_state_nxt == S_PAR_LOAD) begin
            w_byte_data_nxt = w_par_nxt;
        end

        // dcx holds through the trailing delay so it only moves in
        // S_IDLE, S_CMD_LOAD or S_PAR_REQ.
        w_dcx_nxt = 1'b1;
        if ((w_state_nxt == S_CMD_LOAD) || (w_state_nxt == S_CMD_WAIT)) begin
            w_dcx_nxt = 1'b0;
        end else if (w_state_nxt == S_DELAY) begin
            w_dcx_nxt = r_dcx;
        end

        w_cmd_done_nxt = (w_state_nxt == S_DELAY) &&
                         (w_cnt_nxt == CNT_W'(w_delay_nxt));
    end

    assign cmd_ready = r_cmd_ready;
    assign par_ready = r_par_ready;
    assign byte_load = r_byte_load;
    assign byte_data = r_byte_data;
    assign dcx       = r_dcx;
    assign lcd_rst_n = r_lcd_rst_n;
    assign busy      = r_busy;
    assign cmd_done  = r_cmd_done;

endmodule
